// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, oversampling constants and
// divider-width helper used by the receiver, buffer and transmitter.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int SMP_A      = 7;
  localparam int SMP_B      = 8;
  localparam int SMP_C      = 9;

  function automatic int cnt_w(input int div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Byte handshake from the receiver to the downstream word-collecting stage.
interface uart_rx_os_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every DIV clocks, synchronous clear.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV = 78
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  output logic tick
);
  localparam int             W    = cnt_w(DIV);
  localparam logic [W-1:0]   LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST) && !clr;
endmodule

// File: rtl/uart_rx_os.sv
// 16x-oversampled 8N1 receiver with majority voting, false-start rejection,
// framing-error detection and a one-byte holding register.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int FREQ = 12000000,
  parameter int BAUD = 9600,
  parameter int DIV  = FREQ / (BAUD * OVERSAMPLE)
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            rx,
  uart_rx_os_if.master    rxo,
  output logic            frame_err,
  output logic            overrun,
  output logic            busy
);
  localparam logic [3:0] PH_A    = 4'(SMP_A);
  localparam logic [3:0] PH_B    = 4'(SMP_B);
  localparam logic [3:0] PH_C    = 4'(SMP_C);
  localparam logic [3:0] PH_LAST = 4'(OVERSAMPLE - 1);

  rx_state_e   state_q, state_d;
  logic [3:0]  ph_q, ph_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  smp_q, smp_d;
  logic [7:0]  sh_q, sh_d;
  logic        sync1_q, rxs_q, rxs_dly_q;
  logic [1:0]  fill_q, fill_d;
  logic        armed_q, armed_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic        tick, start_edge, maj, decide, byte_done, ferr_evt, load;

  // After reset the synchroniser holds 1s, so a low line would look like a
  // fresh edge; start detection stays disarmed until the real pin reads high.
  assign fill_d     = {fill_q[0], 1'b1};
  assign armed_d    = armed_q | (fill_q[1] & rxs_q);
  assign start_edge = (state_q == IDLE) && armed_q && rxs_dly_q && !rxs_q;
  assign maj        = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);
  assign decide     = tick && (ph_q == PH_C);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .nrst (nrst),
    .clr  (start_edge),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      ph_q      <= '0;
      bit_q     <= '0;
      smp_q     <= '0;
      sh_q      <= '0;
      sync1_q   <= 1'b1;
      rxs_q     <= 1'b1;
      rxs_dly_q <= 1'b1;
      fill_q    <= '0;
      armed_q   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      bit_q     <= bit_d;
      smp_q     <= smp_d;
      sh_q      <= sh_d;
      sync1_q   <= rx;
      rxs_q     <= sync1_q;
      rxs_dly_q <= rxs_q;
      fill_q    <= fill_d;
      armed_q   <= armed_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    smp_d   = smp_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE: if (start_edge) begin
        state_d = START;
        ph_d    = '0;
      end
      WAIT_HIGH: if (rxs_q) state_d = IDLE;
      default: if (tick) begin
        ph_d = ph_q + 1'b1;
        if (ph_q == PH_A) smp_d[0] = rxs_q;
        if (ph_q == PH_B) smp_d[1] = rxs_q;
        if (ph_q == PH_C) begin
          case (state_q)
            START:   if (maj) state_d = IDLE;
            DATA:    sh_d = {maj, sh_q[7:1]};
            STOP:    state_d = maj ? IDLE : WAIT_HIGH;
            default: ;
          endcase
        end
        if (ph_q == PH_LAST) begin
          if (state_q == START) begin
            state_d = DATA;
            bit_d   = '0;
          end else if (state_q == DATA) begin
            if (bit_q == 3'd7) state_d = STOP;
            else               bit_d   = bit_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    byte_done = (state_q == STOP) && decide && maj;
    ferr_evt  = (state_q == STOP) && decide && !maj;
    // A byte may load in the same cycle the consumer takes the old one.
    load      = byte_done && (!valid_q || rxo.rx_ready);
    data_d    = load ? sh_q : data_q;
    valid_d   = load || (valid_q && !rxo.rx_ready);
    ferr_d    = ferr_evt;
    ovr_d     = byte_done && !load;
  end

  assign rxo.rx_data  = data_q;
  assign rxo.rx_valid = valid_q;
  assign frame_err    = ferr_q;
  assign overrun      = ovr_q;
endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at DIV=1: scoreboard of expected bytes,
// pulse counters, and latency/flag checks around each frame.
module tb_uart_rx_os;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic rx = 1'b1;
  logic frame_err, overrun, busy;

  uart_rx_os_if bus ();

  uart_rx_os #(.FREQ(1600), .BAUD(100)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .rx        (rx),
    .rxo       (bus),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int vectors = 0, miscompares = 0;
  int ferr_cnt = 0, ovr_cnt = 0, valid_cnt = 0, hs_cnt = 0, last_hs_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (nrst) begin
      if (frame_err)    ferr_cnt++;
      if (overrun)      ovr_cnt++;
      if (bus.rx_valid) valid_cnt++;
      if (bus.rx_valid && bus.rx_ready) begin
        hs_cnt++;
        last_hs_cyc = cyc;
        chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    idle(16);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  initial begin
    int c0, v0, h0, f0, o0;
    bus.rx_ready = 1'b1;
    idle(3);
    chk("rst_data",  32'(bus.rx_data), 32'd0);
    chk("rst_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_ferr",  32'(frame_err), 32'd0);
    chk("rst_ovr",   32'(overrun), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    nrst = 1'b1;
    idle(5);

    // Clean byte with consumer always ready
    c0 = cyc; v0 = valid_cnt;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    idle(20);
    chk("a5_hs",      32'(hs_cnt), 32'd1);
    chk("a5_latency", 32'(last_hs_cyc - c0), 32'd157);
    chk("a5_vwidth",  32'(valid_cnt - v0), 32'd1);
    chk("a5_flags",   32'(ferr_cnt + ovr_cnt), 32'd0);

    // Short glitch is rejected as a false start
    rx = 1'b0;
    idle(4);
    chk("glitch_busy_hi", 32'(busy), 32'd1);
    rx = 1'b1;
    idle(12);
    chk("glitch_busy_lo", 32'(busy), 32'd0);
    idle(20);
    chk("glitch_noflag", 32'(ferr_cnt + ovr_cnt), 32'd0);
    chk("glitch_nobyte", 32'(hs_cnt), 32'd1);

    // Framing error followed by a held-low line
    send_byte(8'h3C, 1'b0);
    idle(40);
    chk("ferr_once",    32'(ferr_cnt), 32'd1);
    chk("ferr_busy",    32'(busy), 32'd1);
    chk("ferr_novalid", 32'(bus.rx_valid), 32'd0);
    rx = 1'b1;
    idle(5);
    chk("ferr_idle",  32'(busy), 32'd0);
    chk("ferr_still", 32'(ferr_cnt), 32'd1);

    // Overrun: consumer stalled across two bytes
    bus.rx_ready = 1'b0;
    h0 = hs_cnt;
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    idle(10);
    chk("ovr_valid", 32'(bus.rx_valid), 32'd1);
    chk("ovr_data",  32'(bus.rx_data), 32'h11);
    chk("ovr_pulse", 32'(ovr_cnt), 32'd1);
    chk("ovr_nohs",  32'(hs_cnt - h0), 32'd0);
    bus.rx_ready = 1'b1;
    idle(1);
    bus.rx_ready = 1'b0;
    chk("ovr_drain_hs",    32'(hs_cnt - h0), 32'd1);
    chk("ovr_drain_valid", 32'(bus.rx_valid), 32'd0);

    // Handshake in the same cycle 0x55 completes
    exp_q.push_back(8'h66);
    send_byte(8'h66, 1'b1);
    idle(5);
    exp_q.push_back(8'h55);
    o0 = ovr_cnt;
    c0 = cyc;
    fork
      send_byte(8'h55, 1'b1);
      begin
        repeat (c0 + 156 - cyc) @(posedge clk);
        #1 bus.rx_ready = 1'b1;
        @(posedge clk);
        #1 bus.rx_ready = 1'b0;
      end
    join
    idle(5);
    chk("coin_valid", 32'(bus.rx_valid), 32'd1);
    chk("coin_data",  32'(bus.rx_data), 32'h55);
    chk("coin_noovr", 32'(ovr_cnt - o0), 32'd0);
    bus.rx_ready = 1'b1;
    idle(3);
    chk("coin_drain", 32'(bus.rx_valid), 32'd0);

    // Reset mid-frame, released while the line is low
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    nrst = 1'b0;
    #1;
    chk("mid_rst_busy",  32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(bus.rx_valid), 32'd0);
    chk("mid_rst_data",  32'(bus.rx_data), 32'd0);
    chk("mid_rst_flags", 32'({frame_err, overrun}), 32'd0);
    rx = 1'b0;
    idle(3);
    nrst = 1'b1;
    idle(40);
    chk("low_after_rst", 32'(busy), 32'd0);
    rx = 1'b1;
    idle(20);
    h0 = hs_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    exp_q.push_back(8'h0F);
    send_byte(8'h0F, 1'b1);
    idle(20);
    chk("post_rst_hs",    32'(hs_cnt - h0), 32'd1);
    chk("post_rst_flags", 32'((ferr_cnt - f0) + (ovr_cnt - o0)), 32'd0);
    chk("sb_drained",     32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
